// File: rtl/lifo_stack_ctrl.sv
// lifo_stack_ctrl: register-array LIFO stack with a stack pointer equal to the
// entry count, level flags, and sticky overflow/underflow error flags.
//
// Request semantics: push and pop are single-cycle requests with no
// back-pressure. Every request present at a rising edge is acted on in that
// cycle. A request that cannot be honoured is dropped, and the matching
// sticky error flag is set. pop_data always shows the current top of stack,
// so a popped word is read in the same cycle that pop is asserted.
module lifo_stack_ctrl #(
    parameter int B        = 8,
    parameter int W        = 4,
    parameter int AF_LEVEL = 2**W - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic         err_clr,
    input  logic [B-1:0] push_data,
    output logic [B-1:0] pop_data,
    output logic [W:0]   count,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic         overflow,
    output logic         underflow
);

    localparam int        D      = 2**W;
    localparam logic [W:0] DEPTH  = (W+1)'(D);
    localparam logic [W:0] ONE    = (W+1)'(1);
    localparam logic [W:0] AF_CNT = (W+1)'(AF_LEVEL);
    localparam logic [W:0] AE_CNT = (W+1)'(AE_LEVEL);

    logic [B-1:0] mem [D];
    logic [W:0]   sp;
    logic [W:0]   sp_next;
    logic [W:0]   sp_dec;
    logic [W-1:0] top_idx;
    logic         we;
    logic [W-1:0] waddr;
    logic         set_ovf;
    logic         set_unf;
    logic         is_empty;
    logic         is_full;

    assign is_empty = (sp == '0);
    assign is_full  = (sp == DEPTH);
    assign sp_dec   = sp - ONE;
    // When sp == D the low W bits wrap to D-1, which is the correct top index.
    assign top_idx  = sp_dec[W-1:0];

    assign pop_data     = is_empty ? '0 : mem[top_idx];
    assign count        = sp;
    assign empty        = is_empty;
    assign full         = is_full;
    assign almost_empty = (sp <= AE_CNT);
    assign almost_full  = (sp >= AF_CNT);

    // Decode one operation per cycle: clear wins; otherwise push/pop combination.
    always_comb begin
        sp_next = sp;
        we      = 1'b0;
        waddr   = sp[W-1:0];
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (clear) begin
            sp_next = '0;
        end else if (push && pop) begin
            if (is_empty) begin
                // Nothing to pop: the push still happens, the pop is refused.
                we      = 1'b1;
                waddr   = '0;
                sp_next = ONE;
                set_unf = 1'b1;
            end else begin
                // Replace the top entry in place.
                we    = 1'b1;
                waddr = top_idx;
            end
        end else if (push) begin
            if (!is_full) begin
                we      = 1'b1;
                waddr   = sp[W-1:0];
                sp_next = sp + ONE;
            end else begin
                set_ovf = 1'b1;
            end
        end else if (pop) begin
            if (!is_empty) begin
                sp_next = sp_dec;
            end else begin
                set_unf = 1'b1;
            end
        end
    end

    // Stack pointer and sticky error flags; a new error wins over err_clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_next;
            overflow  <= set_ovf | (overflow & ~err_clr);
            underflow <= set_unf | (underflow & ~err_clr);
        end
    end

    // Storage array: contents are not reset, but reset blocks any pending write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // Hold contents; only the pending write is suppressed.
        end else if (we) begin
            mem[waddr] <= push_data;
        end
    end

endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// Self-checking bench for lifo_stack_ctrl: directed scenarios plus random
// traffic, all compared against a queue-based stack model.
`timescale 1ns/1ps
module tb_lifo_stack_ctrl;

    localparam int B = 8;
    localparam int W = 4;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         push = 1'b0;
    logic         pop = 1'b0;
    logic         clear = 1'b0;
    logic         err_clr = 1'b0;
    logic [B-1:0] push_data = '0;
    logic [B-1:0] pop_data;
    logic [W:0]   count;
    logic         empty;
    logic         full;
    logic         almost_empty;
    logic         almost_full;
    logic         overflow;
    logic         underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: the stack contents as a queue (back = top) plus flags.
    logic [B-1:0] exp_q[$];
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;

    lifo_stack_ctrl #(.B(B), .W(W)) dut (
        .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .clear(clear),
        .err_clr(err_clr), .push_data(push_data), .pop_data(pop_data),
        .count(count), .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = exp_q.size();
        check_eq({tag, ":count"}, 32'(count), 32'(n));
        check_eq({tag, ":pop_data"}, 32'(pop_data), (n > 0) ? 32'(exp_q[n-1]) : 32'd0);
        check_eq({tag, ":empty"}, 32'(empty), 32'(n == 0));
        check_eq({tag, ":full"}, 32'(full), 32'(n == D));
        check_eq({tag, ":almost_empty"}, 32'(almost_empty), 32'(n <= 1));
        check_eq({tag, ":almost_full"}, 32'(almost_full), 32'(n >= D - 2));
        check_eq({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
        check_eq({tag, ":underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    // Apply one clock's worth of stack rules to the model.
    task automatic model_step(input bit pu, input bit po, input bit cl, input bit ec,
                              input logic [B-1:0] d);
        bit so;
        bit su;
        so = 1'b0;
        su = 1'b0;
        if (cl) begin
            exp_q.delete();
        end else if (pu && po) begin
            if (exp_q.size() == 0) begin
                exp_q.push_back(d);
                su = 1'b1;
            end else begin
                exp_q[exp_q.size()-1] = d;
            end
        end else if (pu) begin
            if (exp_q.size() < D) exp_q.push_back(d);
            else so = 1'b1;
        end else if (po) begin
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            else su = 1'b1;
        end
        m_ovf = so | (m_ovf & ~ec);
        m_unf = su | (m_unf & ~ec);
    endtask

    // Drive one cycle from a falling edge, then check at the next falling edge.
    task automatic do_cycle(input bit pu, input bit po, input bit cl, input bit ec,
                            input logic [B-1:0] d, input string tag);
        push      = pu;
        pop       = po;
        clear     = cl;
        err_clr   = ec;
        push_data = d;
        #1;
        if (po && !pu && !cl && exp_q.size() > 0)
            check_eq({tag, ":popped"}, 32'(pop_data), 32'(exp_q[exp_q.size()-1]));
        model_step(pu, po, cl, ec, d);
        @(posedge clk);
        @(negedge clk);
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        err_clr = 1'b0;
        check_model(tag);
    endtask

    task automatic do_push(input logic [B-1:0] d, input string tag);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, d, tag);
    endtask

    task automatic do_pop(input string tag);
        do_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, tag);
    endtask

    initial begin
        // Reset phase.
        #12;
        check_model("reset");
        check_eq("reset:count_const", 32'(count), 32'd0);
        check_eq("reset:pop_data_const", 32'(pop_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Three pushes then three pops.
        do_push(8'h11, "p3a");
        do_push(8'h22, "p3b");
        do_push(8'h33, "p3c");
        check_eq("p3:count", 32'(count), 32'd3);
        check_eq("p3:top", 32'(pop_data), 32'h33);
        check_eq("pop1:value", 32'(pop_data), 32'h33);
        do_pop("pop1");
        check_eq("pop2:value", 32'(pop_data), 32'h22);
        do_pop("pop2");
        check_eq("pop3:value", 32'(pop_data), 32'h11);
        do_pop("pop3");
        check_eq("drained:empty", 32'(empty), 32'd1);
        check_eq("drained:pop_data", 32'(pop_data), 32'd0);

        // Fill to full, then overflow.
        for (int i = 0; i < D; i++) begin
            do_push(8'(i), "fill");
            check_eq("fill:almost_full", 32'(almost_full), 32'(i + 1 >= 14));
        end
        check_eq("fill:full", 32'(full), 32'd1);
        check_eq("fill:count", 32'(count), 32'd16);
        do_push(8'hEE, "ovf");
        check_eq("ovf:count", 32'(count), 32'd16);
        check_eq("ovf:top", 32'(pop_data), 32'h0F);
        check_eq("ovf:flag", 32'(overflow), 32'd1);
        do_cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, "ovf_clr");
        check_eq("ovf_clr:flag", 32'(overflow), 32'd0);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, "clr1");

        // Simultaneous push and pop replaces the top.
        for (int i = 0; i < 5; i++) do_push(8'h40 + 8'(i), "rep_fill");
        check_eq("rep:pre_top", 32'(pop_data), 32'h44);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA, "rep5");
        check_eq("rep5:count", 32'(count), 32'd5);
        check_eq("rep5:top", 32'(pop_data), 32'hAA);
        check_eq("rep5:err", 32'({overflow, underflow}), 32'd0);
        for (int i = 0; i < 11; i++) do_push(8'($urandom_range(0, 255)), "rep_fill2");
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'hBB, "rep16");
        check_eq("rep16:full", 32'(full), 32'd1);
        check_eq("rep16:top", 32'(pop_data), 32'hBB);
        check_eq("rep16:ovf", 32'(overflow), 32'd0);

        // Underflow behaviour.
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, "clr2");
        do_pop("unf_pop");
        check_eq("unf_pop:flag", 32'(underflow), 32'd1);
        check_eq("unf_pop:count", 32'(count), 32'd0);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, "unf_pp");
        check_eq("unf_pp:count", 32'(count), 32'd1);
        check_eq("unf_pp:top", 32'(pop_data), 32'h5A);
        check_eq("unf_pp:flag", 32'(underflow), 32'd1);
        do_cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, "unf_clr");
        check_eq("unf_clr:flag", 32'(underflow), 32'd0);
        do_pop("unf_drain");
        do_cycle(1'b0, 1'b1, 1'b0, 1'b1, '0, "unf_setwins");
        check_eq("unf_setwins:flag", 32'(underflow), 32'd1);

        // Clear has priority over push and keeps error flags.
        for (int i = 0; i < 7; i++) do_push(8'h70 + 8'(i), "clr_fill");
        do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'hCC, "clr_push");
        check_eq("clr_push:count", 32'(count), 32'd0);
        check_eq("clr_push:empty", 32'(empty), 32'd1);
        check_eq("clr_push:unf_kept", 32'(underflow), 32'd1);

        // Asynchronous reset between edges with a push pending.
        for (int i = 0; i < 9; i++) do_push(8'h90 + 8'(i), "rst_fill");
        push      = 1'b1;
        push_data = 8'hDD;
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_model("async_rst");
        check_eq("async_rst:count", 32'(count), 32'd0);
        check_eq("async_rst:empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        check_model("async_rst_edge");
        @(negedge clk);
        push    = 1'b0;
        reset_n = 1'b1;
        do_push(8'h77, "post_rst");
        check_eq("post_rst:count", 32'(count), 32'd1);
        check_eq("post_rst:top", 32'(pop_data), 32'h77);

        // Random traffic: push-heavy, then pop-heavy, to visit both ends.
        for (int i = 0; i < 600; i++) begin
            bit pu;
            bit po;
            bit cl;
            bit ec;
            if (i < 300) begin
                pu = ($urandom_range(0, 99) < 70);
                po = ($urandom_range(0, 99) < 35);
            end else begin
                pu = ($urandom_range(0, 99) < 35);
                po = ($urandom_range(0, 99) < 70);
            end
            cl = ($urandom_range(0, 59) == 0);
            ec = ($urandom_range(0, 9) == 0);
            do_cycle(pu, po, cl, ec, 8'($urandom_range(0, 255)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
